// File: rtl/mem_access_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit_if
// Description : Data-memory bus between the MEM-stage access sequencer and
//               the single-ported data memory.
// Revision    : 1.0
// ============================================================================
interface mem_access_unit_if;
    logic [15:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_wmask;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_resp;

    modport master (
        output mem_address, mem_read, mem_write, mem_wmask, mem_wdata,
        input  mem_rdata, mem_resp
    );

    modport slave (
        input  mem_address, mem_read, mem_write, mem_wmask, mem_wdata,
        output mem_rdata, mem_resp
    );
endinterface
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : LC-3b MEM-stage sequencer: word/byte loads and stores,
//               LDI/STI pointer indirection, pipeline stall generation.
// Revision    : 1.0
// ============================================================================
module mem_access_unit (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    input  logic                      req_load,
    input  logic                      req_store,
    input  logic                      req_ldi_sti,
    input  logic                      req_byte,
    input  logic [15:0]               req_addr,
    input  logic [15:0]               req_wdata,
    mem_access_unit_if.master         mem,
    output logic [15:0]               load_data,
    output logic                      done,
    output logic                      stall
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_INDIR = 2'd1,
        S_DATA  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_is_load;
    logic        r_byte;
    logic [15:0] r_wdata;
    logic [15:0] r_daddr;

    logic        w_request;
    logic        w_from_ptr;
    logic        w_enter_data;
    logic [15:0] w_daddr;
    logic        w_load;
    logic        w_byte;
    logic [15:0] w_wdata_src;
    logic [15:0] w_bus_addr;
    logic [15:0] w_bus_wdata;
    logic [1:0]  w_bus_wmask;
    logic [7:0]  w_rbyte;
    logic [15:0] w_load_val;

    // Data-phase bus values come from the live request when entering DATA
    // from IDLE, or from the latched flags plus the fetched pointer from INDIR.
    always_comb begin
        w_request    = req_valid & (req_load | req_store);
        w_from_ptr   = (r_state == S_INDIR);
        w_enter_data = ((r_state == S_IDLE) & w_request & ~req_ldi_sti) |
                       (w_from_ptr & mem.mem_resp);
        w_daddr      = w_from_ptr ? mem.mem_rdata : req_addr;
        w_load       = w_from_ptr ? r_is_load     : req_load;
        w_byte       = w_from_ptr ? r_byte        : req_byte;
        w_wdata_src  = w_from_ptr ? r_wdata       : req_wdata;
        w_bus_addr   = w_byte ? w_daddr : {w_daddr[15:1], 1'b0};
        w_bus_wdata  = w_byte ? {w_wdata_src[7:0], w_wdata_src[7:0]} : w_wdata_src;
        if (w_load)
            w_bus_wmask = 2'b00;
        else if (w_byte)
            w_bus_wmask = w_daddr[0] ? 2'b10 : 2'b01;
        else
            w_bus_wmask = 2'b11;
        w_rbyte      = r_daddr[0] ? mem.mem_rdata[15:8] : mem.mem_rdata[7:0];
        w_load_val   = r_byte ? {{8{w_rbyte[7]}}, w_rbyte} : mem.mem_rdata;
        stall        = ((r_state == S_IDLE) & w_request) |
                       (r_state == S_INDIR) | (r_state == S_DATA);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= S_IDLE;
            r_is_load       <= 1'b0;
            r_byte          <= 1'b0;
            r_wdata         <= 16'h0000;
            r_daddr         <= 16'h0000;
            mem.mem_address <= 16'h0000;
            mem.mem_read    <= 1'b0;
            mem.mem_write   <= 1'b0;
            mem.mem_wmask   <= 2'b00;
            mem.mem_wdata   <= 16'h0000;
            load_data       <= 16'h0000;
            done            <= 1'b0;
        end else begin
            if (w_enter_data) begin
                r_state         <= S_DATA;
                r_daddr         <= w_daddr;
                mem.mem_address <= w_bus_addr;
                mem.mem_read    <= w_load;
                mem.mem_write   <= ~w_load;
                mem.mem_wmask   <= w_bus_wmask;
                mem.mem_wdata   <= w_bus_wdata;
            end

            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (w_request) begin
                        r_is_load <= req_load;
                        r_byte    <= req_byte;
                        r_wdata   <= req_wdata;
                        if (req_ldi_sti) begin
                            r_state         <= S_INDIR;
                            mem.mem_address <= {req_addr[15:1], 1'b0};
                            mem.mem_read    <= 1'b1;
                            mem.mem_write   <= 1'b0;
                            mem.mem_wmask   <= 2'b00;
                            mem.mem_wdata   <= 16'h0000;
                        end
                    end
                end
                S_INDIR: begin
                    done <= 1'b0;
                end
                S_DATA: begin
                    if (mem.mem_resp) begin
                        if (r_is_load)
                            load_data <= w_load_val;
                        mem.mem_read  <= 1'b0;
                        mem.mem_write <= 1'b0;
                        mem.mem_wmask <= 2'b00;
                        done          <= 1'b1;
                        r_state       <= S_DONE;
                    end
                end
                default: begin
                    // Request inputs still describe the retiring instruction here.
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Directed self-checking bench for mem_access_unit.
// Revision    : 1.0
// ============================================================================
module tb_mem_access_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid, req_load, req_store, req_ldi_sti, req_byte;
    logic [15:0] req_addr, req_wdata;
    logic [15:0] load_data;
    logic        done, stall;

    mem_access_unit_if bus ();

    mem_access_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_load    (req_load),
        .req_store   (req_store),
        .req_ldi_sti (req_ldi_sti),
        .req_byte    (req_byte),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .mem         (bus),
        .load_data   (load_data),
        .done        (done),
        .stall       (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [15:0] ph_addr [2];
    logic [15:0] ph_wdata[2];
    logic [1:0]  ph_mask [2];
    logic        ph_rd   [2];
    logic        ph_wr   [2];
    int          done_cyc, stall_cyc;
    bit          gap, unstable, both;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0;
        req_ldi_sti = 1'b0; req_byte = 1'b0;
        bus.mem_resp = 1'b0;
        tick;
    endtask

    // Presents one request and plays a memory that answers each phase after
    // w0/w1 extra wait cycles; records what the bus showed in each phase.
    task automatic access(input logic [15:0] a, input logic [15:0] wd,
                          input logic ld, input logic st, input logic ind, input logic byt,
                          input logic [15:0] rd0, input logic [15:0] rd1,
                          input int w0, input int w1);
        int ph, pcnt;
        ph = 0; pcnt = 0; done_cyc = -1; stall_cyc = 0;
        gap = 0; unstable = 0; both = 0;
        for (int i = 0; i < 2; i++) begin
            ph_addr[i] = 16'h0; ph_wdata[i] = 16'h0; ph_mask[i] = 2'b00;
            ph_rd[i] = 1'b0; ph_wr[i] = 1'b0;
        end
        tick;
        req_valid = 1'b1; req_load = ld; req_store = st; req_ldi_sti = ind;
        req_byte = byt; req_addr = a; req_wdata = wd;
        for (int c = 0; c < 64; c++) begin
            if (c > 0) tick;
            bus.mem_resp = 1'b0;
            #1;
            if (done) begin done_cyc = c; break; end
            if (stall) stall_cyc++; else gap = 1;
            if (bus.mem_read & bus.mem_write) both = 1;
            if ((bus.mem_read | bus.mem_write) && ph < 2) begin
                if (pcnt == 0) begin
                    ph_addr[ph] = bus.mem_address; ph_wdata[ph] = bus.mem_wdata;
                    ph_mask[ph] = bus.mem_wmask; ph_rd[ph] = bus.mem_read;
                    ph_wr[ph] = bus.mem_write;
                end else if (ph_addr[ph] !== bus.mem_address || ph_wdata[ph] !== bus.mem_wdata ||
                             ph_mask[ph] !== bus.mem_wmask || ph_rd[ph] !== bus.mem_read ||
                             ph_wr[ph] !== bus.mem_write) begin
                    unstable = 1;
                end
                if (pcnt == ((ph == 0) ? w0 : w1)) begin
                    bus.mem_resp  = 1'b1;
                    bus.mem_rdata = (ph == 0) ? rd0 : rd1;
                    ph++; pcnt = 0;
                end else begin
                    pcnt++;
                end
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        idle; idle;
        #1;
        total++; if ({bus.mem_read, bus.mem_write, bus.mem_wmask, done, stall} !== 6'b0) begin bad++; $display("FAIL reset_ctrl: got %b want 000000", {bus.mem_read, bus.mem_write, bus.mem_wmask, done, stall}); end
        total++; if ({bus.mem_address, bus.mem_wdata, load_data} !== 48'h0) begin bad++; $display("FAIL reset_data: got %h want 0", {bus.mem_address, bus.mem_wdata, load_data}); end
        rst_n = 1'b1;
        tick; #1;
        total++; if ({stall, done} !== 2'b00) begin bad++; $display("FAIL reset_release: stall/done got %b want 00", {stall, done}); end
    endtask

    task automatic test_ldr;
        access(16'h3005, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'hBEEF, 16'h0, 0, 0);
        total++; if (ph_addr[0] !== 16'h3004) begin bad++; $display("FAIL ldr_addr: got %h want 3004", ph_addr[0]); end
        total++; if ({ph_rd[0], ph_wr[0], ph_mask[0]} !== 4'b1000) begin bad++; $display("FAIL ldr_rw_mask: got %b want 1000", {ph_rd[0], ph_wr[0], ph_mask[0]}); end
        total++; if (stall_cyc !== 2 || gap) begin bad++; $display("FAIL ldr_stall: got %0d gap=%0d want 2 gap=0", stall_cyc, gap); end
        total++; if (done_cyc !== 2) begin bad++; $display("FAIL ldr_done_cycle: got %0d want 2", done_cyc); end
        total++; if (load_data !== 16'hBEEF) begin bad++; $display("FAIL ldr_data: got %h want beef", load_data); end
        idle; #1;
        total++; if ({done, stall} !== 2'b00) begin bad++; $display("FAIL ldr_after: done/stall got %b want 00", {done, stall}); end
    endtask

    task automatic test_ldb;
        access(16'h4001, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'h80FF, 16'h0, 0, 0);
        total++; if (ph_addr[0] !== 16'h4001) begin bad++; $display("FAIL ldb_hi_addr: got %h want 4001", ph_addr[0]); end
        total++; if (load_data !== 16'hFF80) begin bad++; $display("FAIL ldb_hi_data: got %h want ff80", load_data); end
        // issued back to back: accepted in the IDLE cycle right after DONE
        access(16'h4000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'h807F, 16'h0, 1, 0);
        total++; if (load_data !== 16'h007F) begin bad++; $display("FAIL ldb_lo_data: got %h want 007f", load_data); end
        total++; if (done_cyc !== 3) begin bad++; $display("FAIL ldb_lo_done_cycle: got %0d want 3", done_cyc); end
        idle;
    endtask

    task automatic test_stores;
        access(16'h5001, 16'h12AB, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0, 16'h0, 2, 0);
        total++; if ({ph_rd[0], ph_wr[0], ph_mask[0]} !== 4'b0110) begin bad++; $display("FAIL stb_hi_rw_mask: got %b want 0110", {ph_rd[0], ph_wr[0], ph_mask[0]}); end
        total++; if (ph_wdata[0] !== 16'hABAB || ph_addr[0] !== 16'h5001) begin bad++; $display("FAIL stb_hi_bus: got %h@%h want abab@5001", ph_wdata[0], ph_addr[0]); end
        total++; if (unstable || both) begin bad++; $display("FAIL stb_hi_stable: got unstable=%0d both=%0d want 0 0", unstable, both); end
        total++; if (load_data !== 16'h007F) begin bad++; $display("FAIL stb_keeps_load: got %h want 007f", load_data); end
        access(16'h5000, 16'h12AB, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0, 16'h0, 0, 0);
        total++; if ({ph_wr[0], ph_mask[0], ph_wdata[0], ph_addr[0]} !== {1'b1, 2'b01, 16'hABAB, 16'h5000}) begin bad++; $display("FAIL stb_lo_bus: got %b %b %h %h want 1 01 abab 5000", ph_wr[0], ph_mask[0], ph_wdata[0], ph_addr[0]); end
        access(16'h2003, 16'h5A5A, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1, 0);
        total++; if ({ph_mask[0], ph_wdata[0], ph_addr[0]} !== {2'b11, 16'h5A5A, 16'h2002}) begin bad++; $display("FAIL str_bus: got %b %h %h want 11 5a5a 2002", ph_mask[0], ph_wdata[0], ph_addr[0]); end
        total++; if (done_cyc !== 3 || stall_cyc !== 3) begin bad++; $display("FAIL str_timing: got done=%0d stall=%0d want 3 3", done_cyc, stall_cyc); end
        // load and store both set is treated as a load
        access(16'h2100, 16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0F0F, 16'h0, 0, 0);
        total++; if ({ph_rd[0], ph_wr[0], ph_mask[0]} !== 4'b1000 || load_data !== 16'h0F0F) begin bad++; $display("FAIL ld_st_both: got %b %h want 1000 0f0f", {ph_rd[0], ph_wr[0], ph_mask[0]}, load_data); end
        idle;
    endtask

    task automatic test_indirect;
        access(16'h6000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 16'h7002, 16'h1234, 3, 3);
        total++; if (ph_addr[0] !== 16'h6000 || ph_rd[0] !== 1'b1) begin bad++; $display("FAIL ldi_ptr_read: got %h rd=%b want 6000 rd=1", ph_addr[0], ph_rd[0]); end
        total++; if (ph_addr[1] !== 16'h7002 || ph_rd[1] !== 1'b1) begin bad++; $display("FAIL ldi_data_read: got %h rd=%b want 7002 rd=1", ph_addr[1], ph_rd[1]); end
        total++; if (load_data !== 16'h1234) begin bad++; $display("FAIL ldi_data: got %h want 1234", load_data); end
        total++; if (done_cyc !== 9 || stall_cyc !== 9 || gap || unstable) begin bad++; $display("FAIL ldi_timing: got done=%0d stall=%0d gap=%0d unstable=%0d want 9 9 0 0", done_cyc, stall_cyc, gap, unstable); end
        access(16'h8001, 16'h00C3, 1'b0, 1'b1, 1'b1, 1'b0, 16'h8101, 16'h0, 0, 0);
        total++; if ({ph_rd[0], ph_wr[0], ph_addr[0]} !== {1'b1, 1'b0, 16'h8000}) begin bad++; $display("FAIL sti_ptr_read: got %b%b %h want 10 8000", ph_rd[0], ph_wr[0], ph_addr[0]); end
        total++; if ({ph_rd[1], ph_wr[1], ph_mask[1], ph_wdata[1], ph_addr[1]} !== {1'b0, 1'b1, 2'b11, 16'h00C3, 16'h8100}) begin bad++; $display("FAIL sti_write: got %b%b %b %h %h want 01 11 00c3 8100", ph_rd[1], ph_wr[1], ph_mask[1], ph_wdata[1], ph_addr[1]); end
        total++; if (done_cyc !== 3 || both || load_data !== 16'h1234) begin bad++; $display("FAIL sti_timing: got done=%0d both=%0d ld=%h want 3 0 1234", done_cyc, both, load_data); end
        idle;
    endtask

    task automatic test_nonmem;
        tick;
        req_valid = 1'b1; req_load = 1'b0; req_store = 1'b0; req_ldi_sti = 1'b1;
        bus.mem_resp = 1'b1; bus.mem_rdata = 16'hDEAD;
        for (int c = 0; c < 3; c++) begin
            #1;
            total++; if ({stall, bus.mem_read, bus.mem_write, done} !== 4'b0000) begin bad++; $display("FAIL nonmem_c%0d: stall/rd/wr/done got %b want 0000", c, {stall, bus.mem_read, bus.mem_write, done}); end
            tick;
        end
        idle;
    endtask

    task automatic test_reset_mid;
        tick;
        req_valid = 1'b1; req_load = 1'b1; req_store = 1'b0; req_ldi_sti = 1'b0;
        req_byte = 1'b0; req_addr = 16'h1235; req_wdata = 16'hFFFF;
        tick; #1;
        total++; if (bus.mem_read !== 1'b1) begin bad++; $display("FAIL midrst_pre_read: got %b want 1", bus.mem_read); end
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        total++; if ({bus.mem_read, bus.mem_write, bus.mem_wmask, done, stall} !== 6'b0) begin bad++; $display("FAIL midrst_ctrl: got %b want 000000", {bus.mem_read, bus.mem_write, bus.mem_wmask, done, stall}); end
        total++; if ({bus.mem_address, bus.mem_wdata, load_data} !== 48'h0) begin bad++; $display("FAIL midrst_data: got %h want 0", {bus.mem_address, bus.mem_wdata, load_data}); end
        tick; tick;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick; #1;
            total++; if ({done, stall, bus.mem_read} !== 3'b000) begin bad++; $display("FAIL midrst_after_c%0d: done/stall/rd got %b want 000", c, {done, stall, bus.mem_read}); end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0; req_ldi_sti = 1'b0;
        req_byte = 1'b0; req_addr = 16'h0; req_wdata = 16'h0;
        bus.mem_resp = 1'b0; bus.mem_rdata = 16'h0;
        test_reset;
        test_ldr;
        test_ldb;
        test_stores;
        test_indirect;
        test_nonmem;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
